// File: rtl/bus_ep_pkg.sv
// bus_ep_pkg: shared constants and helpers for the bus endpoint.
//   DEST_W            width of the destination ID field at the top of a packet
//   PKT_MAX_W         widest packet dest_of() accepts (callers zero-extend)
//   BROADCAST_DEFAULT destination ID that every endpoint accepts
//   DROP_CNT_MAX      saturation value of the dropped-push counter
package bus_ep_pkg;

  localparam int DEST_W    = 8;
  localparam int PKT_MAX_W = 64;

  localparam logic [DEST_W-1:0] BROADCAST_DEFAULT = 8'hFF;
  localparam logic [7:0]        DROP_CNT_MAX      = 8'hFF;

  // Destination ID of a packet pkt_w bits wide, passed zero-extended to
  // PKT_MAX_W so one function serves every packet width.
  function automatic logic [DEST_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                                input int pkt_w);
    return DEST_W'(pkt >> (pkt_w - DEST_W));
  endfunction

endpackage

// File: rtl/ep_fifo.sv
// ep_fifo: synchronous show-ahead FIFO.
//   clk, reset   clock, asynchronous active-low reset
//   wr, wr_data  write request/data (ignored while full)
//   rd           read request, advances the head (ignored while empty)
//   rd_data      current head, 0 while empty
//   full, empty  occupancy flags
//   count        number of stored entries, 0..depth
module ep_fifo
  import bus_ep_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  // Extra wrap bit distinguishes full (wrap bits differ) from empty (equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // Full/empty are judged on the pre-edge state, so a write into a full FIFO
  // is refused even when a read happens on the same edge.
  assign wr_en = wr && !full;
  assign rd_en = rd && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; clearing the pointers empties
  // the FIFO and the head is masked below, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/bus_endpoint.sv
// bus_endpoint: device side of the pndng/pop/D_pop and push/D_push bus
// handshakes, with a TX FIFO popped by the bus and an RX FIFO drained by the
// local host. Inbound packets are filtered by destination ID.
//   clk, reset            clock, asynchronous active-low reset
//   pndng, D_pop, pop     bus side of the TX FIFO
//   push, D_push          bus delivery into the RX FIFO
//   tx_valid/data/ready   host write port of the TX FIFO
//   rx_valid/data/ready   host read port of the RX FIFO
//   tx_count, rx_count    FIFO occupancies
//   err_ovf               sticky: valid push dropped because RX was full
//   err_misroute          sticky: push carried a foreign destination
//   err_underflow         sticky: pop arrived with TX empty
//   drop_cnt              saturating count of dropped pushes
module bus_endpoint
  import bus_ep_pkg::*;
#(
  parameter int                pckg_sz   = 16,
  parameter int                depth     = 8,
  parameter logic [DEST_W-1:0] id        = 8'd0,
  parameter logic [DEST_W-1:0] broadcast = BROADCAST_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     pndng,
  output logic [pckg_sz-1:0]       D_pop,
  input  logic                     pop,
  input  logic                     push,
  input  logic [pckg_sz-1:0]       D_push,
  input  logic                     tx_valid,
  input  logic [pckg_sz-1:0]       tx_data,
  output logic                     tx_ready,
  output logic                     rx_valid,
  output logic [pckg_sz-1:0]       rx_data,
  input  logic                     rx_ready,
  output logic [$clog2(depth):0]   tx_count,
  output logic [$clog2(depth):0]   rx_count,
  output logic                     err_ovf,
  output logic                     err_misroute,
  output logic                     err_underflow,
  output logic [7:0]               drop_cnt
);

  logic              tx_full;
  logic              tx_empty;
  logic              rx_full;
  logic              rx_empty;
  logic [DEST_W-1:0] dest;
  logic              dest_ok;
  logic              misroute;
  logic              overflow;

  ep_fifo #(.W(pckg_sz), .DEPTH(depth)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (tx_valid),
    .wr_data (tx_data),
    .rd      (pop),
    .rd_data (D_pop),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  ep_fifo #(.W(pckg_sz), .DEPTH(depth)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (push && dest_ok),
    .wr_data (D_push),
    .rd      (rx_ready),
    .rd_data (rx_data),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  assign pndng    = !tx_empty;
  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;

  assign dest     = dest_of(PKT_MAX_W'(D_push), pckg_sz);
  assign dest_ok  = (dest == id) || (dest == broadcast);

  // Misroute takes precedence: a foreign packet into a full RX is reported
  // only as a misroute, and either way counts as a single drop.
  assign misroute = push && !dest_ok;
  assign overflow = push && dest_ok && rx_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_ovf       <= 1'b0;
      err_misroute  <= 1'b0;
      err_underflow <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      if (overflow)      err_ovf       <= 1'b1;
      if (misroute)      err_misroute  <= 1'b1;
      if (pop && tx_empty) err_underflow <= 1'b1;
      if ((misroute || overflow) && (drop_cnt != DROP_CNT_MAX))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
